// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Instruction prefetch queue. Issues sequential word fetches to
//               the instruction memory, buffers in-order responses as
//               {pc, instr} entries and presents the head entry to ID.
//               Redirects flush the queue and discard stale in-flight data.
//               Optional macro IFQ_HALT_DETECT_EN: stop fetching after an
//               HLT (opcode 4'hF) instruction has been queued.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_OUT_W = $clog2(MAX_OUT + 1);

    logic [15:0]        r_pc_q    [DEPTH];
    logic [15:0]        r_instr_q [DEPTH];
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_OUT_W-1:0] r_outstanding;
    logic [c_OUT_W-1:0] r_drop_cnt;
    logic [15:0]        r_fetch_pc;
    logic [15:0]        r_resp_pc;

    logic               w_halted;
    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_occupancy;

    // Reserve queue space for every request in flight, so a response can
    // always be pushed even when the queue is one entry from full.
    assign w_occupancy = 32'(r_count) + 32'(r_outstanding);
    assign mem_req     = !rst
                         && (w_occupancy < 32'(DEPTH))
                         && (32'(r_outstanding) < 32'(MAX_OUT))
                         && !redirect_valid
                         && !w_halted;
    assign mem_addr    = r_fetch_pc;
    assign w_grant     = mem_req && mem_gnt;

    // Responses during a redirect, while dropping stale data, or after a
    // halt are consumed but never enter the queue.
    assign w_push      = mem_rvalid && !redirect_valid && (r_drop_cnt == '0) && !w_halted;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && !stall && !redirect_valid;

    assign out_pc      = out_valid ? r_pc_q[r_rptr]    : 16'h0000;
    assign out_instr   = out_valid ? r_instr_q[r_rptr] : 16'h0000;
    assign halted      = w_halted;

    // Fetch address, in-flight request count and stale-response drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 16'd1;
            end

            case ({w_grant, mem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // A response arriving in the redirect cycle is already gone, so
            // it is not counted among the ones still to be dropped.
            if (redirect_valid) begin
                r_drop_cnt <= mem_rvalid ? (r_outstanding - c_OUT_W'(1)) : r_outstanding;
            end else if (mem_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_OUT_W'(1);
            end
        end
    end

    // Circular buffer bookkeeping: pointers, occupancy and response PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_resp_pc <= '0;
        end else if (redirect_valid) begin
            r_rptr    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_resp_pc <= redirect_pc;
        end else begin
            if (w_push) begin
                r_wptr    <= r_wptr + c_PTR_W'(1);
                r_resp_pc <= r_resp_pc + 16'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; no reset needed since outputs are masked by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_pc_q[r_wptr]    <= r_resp_pc;
            r_instr_q[r_wptr] <= mem_rdata;
        end
    end

`ifdef IFQ_HALT_DETECT_EN
    logic r_halted;

    // Latch HLT once it is queued; only a redirect or reset restarts fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_push && (mem_rdata[15:12] == 4'hF)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule
`default_nettype wire
